// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline latch and fetch control FSM (boot, run, hold, flush)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic [31:0] instr_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_plus1,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} state_t;
  localparam logic [2:0] BUBBLES = 3'(FLUSH_CYCLES);
  state_t state;
  logic [31:0] pc;
  logic [2:0] bubble;
  assign imem_addr = pc;
  assign pc_plus1 = pc + 32'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      ifid_pc <= '0;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
      bubble <= '0;
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (redirect) begin
      pc <= next_pc;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      bubble <= BUBBLES;
      state <= (BUBBLES != 3'd0) ? FLUSH : RUN;
    end else if (stall) begin
      // a stall inside FLUSH freezes the bubble sequence without counting as a hold cycle
      if (state != FLUSH) begin
        stall_count <= stall_count + 32'd1;
        state <= HOLD;
      end
    end else if (state == FLUSH) begin
      pc <= next_pc;
      ifid_pc <= pc;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      bubble <= bubble - 3'd1;
      state <= (bubble <= 3'd1) ? RUN : FLUSH;
    end else begin
      pc <= next_pc;
      ifid_pc <= pc;
      ifid_instr <= instr_rdata;
      ifid_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
      state <= RUN;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with hand-derived per-cycle expectations
module tb_fetch_stage;
  localparam logic [31:0] A = 32'hA000_0000;
  typedef struct {
    logic [31:0] pc, ipc, ins, fc, sc;
    logic v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0, redirect = 1'b0, stall = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] next_pc, instr_rdata, imem_addr, pc_plus1, ifid_pc, ifid_instr, fetch_count, stall_count;
  logic ifid_valid;
  exp_t q[$];
  int total = 0, bad = 0, cyc_n = 0;
  always #5 clk = ~clk;
  assign next_pc = redirect ? tgt : pc_plus1;
  assign instr_rdata = A + imem_addr;
  fetch_stage #(.RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .redirect(redirect), .stall(stall),
    .instr_rdata(instr_rdata), .imem_addr(imem_addr), .pc_plus1(pc_plus1),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL c%0d %s got=%h want=%h", cyc_n, tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] t,
                     input logic [31:0] pc, input logic [31:0] ipc, input logic [31:0] ins,
                     input logic v, input logic [31:0] fc, input logic [31:0] sc);
    exp_t e;
    @(negedge clk);
    rst_n = r; stall = s; redirect = d; tgt = t;
    q.push_back('{pc: pc, ipc: ipc, ins: ins, fc: fc, sc: sc, v: v});
    @(posedge clk);
    #1;
    cyc_n++;
    e = q.pop_front();
    chk("pc", imem_addr, e.pc);
    chk("pc_plus1", pc_plus1, e.pc + 32'd1);
    if (e.v) chk("ifid_pc", ifid_pc, e.ipc);
    chk("ifid_instr", ifid_instr, e.ins);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
    chk("fetch_count", fetch_count, e.fc);
    chk("stall_count", stall_count, e.sc);
  endtask
  initial begin
    // reset holds everything at zero whatever the other inputs do
    cyc(0, 1, 1, 32'h55, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h77, 0, 0, 0, 0, 0, 0);
    if (ifid_pc !== 32'h0) begin bad++; $display("FAIL reset_ifid_pc got=%h want=0", ifid_pc); end
    total++;
    // boot cycle then sequential fetch
    cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 32'h1, 32'h0, A + 32'h0, 1, 1, 0);
    cyc(1, 0, 0, 0, 32'h2, 32'h1, A + 32'h1, 1, 2, 0);
    cyc(1, 0, 0, 0, 32'h3, 32'h2, A + 32'h2, 1, 3, 0);
    cyc(1, 0, 0, 0, 32'h4, 32'h3, A + 32'h3, 1, 4, 0);
    cyc(1, 0, 0, 0, 32'h5, 32'h4, A + 32'h4, 1, 5, 0);
    // three stall cycles at pc 5, then release
    cyc(1, 1, 0, 0, 32'h5, 32'h4, A + 32'h4, 1, 5, 1);
    cyc(1, 1, 0, 0, 32'h5, 32'h4, A + 32'h4, 1, 5, 2);
    cyc(1, 1, 0, 0, 32'h5, 32'h4, A + 32'h4, 1, 5, 3);
    cyc(1, 0, 0, 0, 32'h6, 32'h5, A + 32'h5, 1, 6, 3);
    // redirect to 0x40 with one flush bubble
    cyc(1, 0, 1, 32'h40, 32'h40, 0, 0, 0, 6, 3);
    cyc(1, 0, 0, 0, 32'h41, 0, 0, 0, 6, 3);
    cyc(1, 0, 0, 0, 32'h42, 32'h41, A + 32'h41, 1, 7, 3);
    // redirect beats stall, then stall inside flush freezes without counting
    cyc(1, 1, 1, 32'h80, 32'h80, 0, 0, 0, 7, 3);
    cyc(1, 1, 0, 0, 32'h80, 0, 0, 0, 7, 3);
    cyc(1, 1, 0, 0, 32'h80, 0, 0, 0, 7, 3);
    // reset mid-flush with stall high, boot ignores stall and redirect
    cyc(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h99, 32'h0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 32'h1, 32'h0, A + 32'h0, 1, 1, 0);
    // wrap of pc_plus1 at the top of the address space
    cyc(1, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, A + 32'hFFFF_FFFF, 1, 2, 0);
    cyc(1, 0, 0, 0, 32'h1, 32'h0, A + 32'h0, 1, 3, 0);
    if (q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", q.size()); end
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 1, range 0..7, sets the extra bubble cycles inserted after a redirect.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low; sampled only at posedge clk.
REQ-005 next_pc  input  32  selected next PC from the PC-select mux (PC+1, jump target or register target).
REQ-006 redirect  input  1  high when next_pc is a taken jump/branch target (jumpMem OR or_out).
REQ-007 stall  input  1  hazard unit request to hold the PC and IF/ID.
REQ-008 instr_rdata  input  32  instruction word for imem_addr; combinational read, valid in the same cycle.
REQ-009 imem_addr  output  32  instruction memory address, equal to pc.
REQ-010 pc_plus1  output  32  pc + 1, word-addressed, feeding the mux adder_out input.
REQ-011 ifid_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 ifid_instr  output  32  instruction held in IF/ID; 32'h0 (NOP) when invalid.
REQ-013 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-014 fetch_count  output  32  number of valid IF/ID loads since reset.
REQ-015 stall_count  output  32  number of cycles spent in HOLD since reset.

Function
REQ-016 Internal pc register; imem_addr and pc_plus1 are combinational from pc; pc_plus1 wraps 32'hFFFF_FFFF -> 32'h0.
REQ-017 FSM states: BOOT, RUN, HOLD, FLUSH; BOOT is entered on reset.
REQ-018 BOOT lasts exactly one cycle: no fetch, pc holds RESET_PC, ifid_valid = 0, next state RUN, even if stall or redirect is high.
REQ-019 RUN, stall = 0, redirect = 0: pc <= next_pc; ifid_pc <= pc; ifid_instr <= instr_rdata; ifid_valid <= 1; fetch_count += 1.
REQ-020 Redirect in RUN, HOLD or FLUSH takes priority over stall.
  - pc <= next_pc; ifid_valid <= 0; ifid_instr <= 0.
  - Bubble counter <= FLUSH_CYCLES.
  - Next state FLUSH if FLUSH_CYCLES > 0, else RUN.
REQ-021 RUN with stall = 1 and redirect = 0: pc and IF/ID hold, next state HOLD, and stall_count += 1 in that cycle.
REQ-022 HOLD with stall = 1 and redirect = 0: pc and IF/ID hold, stall_count += 1.
REQ-023 HOLD with stall = 0 and redirect = 0: behaves as RUN for that cycle (load per REQ-019), next state RUN.
REQ-024 FLUSH, stall = 0, redirect = 0: pc <= next_pc; IF/ID loaded with ifid_valid = 0 and ifid_instr = 0; bubble counter -= 1; go to RUN when the counter reaches 0.
REQ-025 FLUSH with stall = 1 and redirect = 0: pc, IF/ID and the bubble counter hold; state remains FLUSH; stall_count does not increment.
REQ-026 Both counters wrap modulo 2^32; fetch_count never increments on an invalid load.
REQ-027 next_pc is sampled only at posedge; its negedge update by the mux sets up the following posedge.

Reset
REQ-028 With rst_n = 0 at posedge, the following take effect regardless of other inputs, including mid-stall and mid-flush:
  - pc <= RESET_PC.
  - ifid_pc <= 0, ifid_instr <= 0, ifid_valid <= 0.
  - fetch_count <= 0, stall_count <= 0, bubble counter <= 0.
  - state <= BOOT.
REQ-029 Outputs hold their reset values while rst_n stays low.

Verification
REQ-030 Reset release, next_pc = pc_plus1, instr_rdata = 32'hA000_0000 + addr -> one BOOT cycle, then ifid_pc = 0, 1, 2 on successive cycles, ifid_valid = 1, fetch_count = 3 after 4 cycles.
REQ-031 Stall high 3 cycles at pc = 5 -> pc stays 5, IF/ID unchanged, stall_count = 3; the first cycle after stall drops loads ifid_pc = 5.
REQ-032 Redirect with next_pc = 32'h40 and FLUSH_CYCLES = 1 -> pc = 32'h40, then two cycles with ifid_valid = 0 and ifid_instr = 0, then ifid_pc = 32'h41 valid; fetch_count excludes the bubbles.
REQ-033 Redirect and stall high together in RUN -> redirect wins: pc = next_pc, state FLUSH, stall_count unchanged.
REQ-034 rst_n low for one cycle during FLUSH with stall high -> pc = RESET_PC, all outputs zero, BOOT, and normal fetch resumes from RESET_PC.
REQ-035 pc = 32'hFFFF_FFFF -> pc_plus1 = 0; after the next advance, pc = 0 and ifid_pc = 32'hFFFF_FFFF.
